// File: rtl/gpmc_sram.sv
// GPMC-attached synchronous SRAM: multiplexed address/data bus, auto-incrementing
// word address, byte-lane writes with write protect, registered read data.
module gpmc_sram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        GPMC_CLK,
    input  logic        RST,
    input  logic [15:0] GPMC_AD_IN,
    output logic [15:0] GPMC_DATA_OUT,
    input  logic        GPMC_CS,
    input  logic        GPMC_ADV,
    input  logic        GPMC_DIR,
    input  logic        GPMC_OE,
    input  logic        GPMC_BE0,
    input  logic        GPMC_BE1,
    input  logic        GPMC_WP
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [15:0]             data_out_reg;

    logic                    addr_latch;
    logic                    read_beat;
    logic                    write_beat;
    logic [1:0]              lane_we;
    logic [1:0]              lane_sel_n;
    logic [15:0]             rd_word;

    // Bus cycle decode in priority order: chip select, then ADV, then read, then write.
    assign addr_latch = !GPMC_CS && !GPMC_ADV;
    assign read_beat  = !GPMC_CS &&  GPMC_ADV && !GPMC_OE &&  GPMC_DIR;
    assign write_beat = !GPMC_CS &&  GPMC_ADV &&  GPMC_OE && !GPMC_DIR &&
                        (!GPMC_BE0 || !GPMC_BE1);

    assign lane_sel_n = {GPMC_BE1, GPMC_BE0};

    // One memory array per byte lane so each lane has a single write port.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            assign lane_we[gi] = write_beat && !GPMC_WP && !lane_sel_n[gi];

            always_ff @(posedge GPMC_CLK) begin
                if (lane_we[gi]) begin
                    lane_mem[addr_reg] <= GPMC_AD_IN[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[addr_reg];
        end
    endgenerate

    always_ff @(posedge GPMC_CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            data_out_reg <= 16'h0000;
        end else if (GPMC_CS) begin
            state_reg <= ST_IDLE;
        end else if (addr_latch) begin
            addr_reg  <= GPMC_AD_IN[ADDR_WIDTH-1:0];
            state_reg <= ST_ADDR;
        end else if (read_beat) begin
            data_out_reg <= rd_word;
            addr_reg     <= addr_reg + ADDR_ONE;
            state_reg    <= ST_READ;
        end else if (write_beat) begin
            // Write-protected beats still consume an address slot.
            addr_reg  <= addr_reg + ADDR_ONE;
            state_reg <= ST_WRITE;
        end
    end

    assign GPMC_DATA_OUT = data_out_reg;

    // Bus phase is tracked for debug visibility only; no output depends on it.
    logic state_unused;
    assign state_unused = ^state_reg;

endmodule

// File: tb/tb_gpmc_sram.sv
// Scoreboard bench for gpmc_sram: a word-array reference model predicts each read beat,
// a monitor pops predictions and checks GPMC_DATA_OUT every cycle.
module tb_gpmc_sram;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ad;
    logic [15:0] dout;
    logic        cs, adv, dir, oe, be0, be1, wp;

    always #5 clk = ~clk;

    gpmc_sram #(.ADDR_WIDTH(AW)) dut (
        .GPMC_CLK      (clk),
        .RST           (rst),
        .GPMC_AD_IN    (ad),
        .GPMC_DATA_OUT (dout),
        .GPMC_CS       (cs),
        .GPMC_ADV      (adv),
        .GPMC_DIR      (dir),
        .GPMC_OE       (oe),
        .GPMC_BE0      (be0),
        .GPMC_BE1      (be1),
        .GPMC_WP       (wp)
    );

    logic [15:0] model_mem [DEPTH];
    logic [AW-1:0] model_addr;
    logic [15:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    // Drive one bus cycle and advance the reference model by the same cycle.
    task automatic drive(input logic c, input logic a, input logic o, input logic d,
                         input logic b0, input logic b1, input logic w,
                         input logic [15:0] data);
        @(negedge clk);
        cs = c; adv = a; oe = o; dir = d; be0 = b0; be1 = b1; wp = w; ad = data;
        if (!c) begin
            if (!a) begin
                model_addr = data[AW-1:0];
            end else if (!o && d) begin
                exp_q.push_back(model_mem[model_addr]);
                model_addr = model_addr + 1'b1;
            end else if (o && !d && (!b0 || !b1)) begin
                if (!w) begin
                    if (!b0) model_mem[model_addr][7:0]  = data[7:0];
                    if (!b1) model_mem[model_addr][15:8] = data[15:8];
                end
                model_addr = model_addr + 1'b1;
            end
        end
    endtask

    task automatic latch(input logic [15:0] a);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a);
    endtask

    task automatic wr(input logic [15:0] d, input logic b0, input logic b1, input logic w);
        drive(1'b0, 1'b1, 1'b1, 1'b0, b0, b1, w, d);
    endtask

    task automatic rd();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'($urandom));
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic check_now(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, want);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        model_addr = '0;
        #1 check_now("async_reset_dout", dout, 16'h0000);
        idle();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Monitor: a read beat seen on the rising edge pops its prediction; every
    // falling edge outside reset checks that the output holds the expected word.
    logic [15:0] exp_dout = 16'h0000;
    logic        was_read = 1'b0;
    always begin
        @(posedge clk);
        was_read = 1'b0;
        if (rst) begin
            exp_dout = 16'h0000;
        end else if (!cs && adv && !oe && dir) begin
            was_read = 1'b1;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_underflow t=%0t got=%h expected=none", $time, dout);
            end else begin
                exp_dout = exp_q.pop_front();
            end
        end
        @(negedge clk);
        if (rst) begin
            exp_dout = 16'h0000;
        end else begin
            tests++;
            if (dout !== exp_dout) begin
                fails++;
                $display("FAIL dout_check t=%0t got=%h expected=%h", $time, dout, exp_dout);
            end else if (was_read) begin
                $display("[TB] read t=%0t data=%h", $time, dout);
            end
        end
    end

    initial begin
        rst = 1'b1;
        cs = 1'b1; adv = 1'b1; oe = 1'b1; dir = 1'b0;
        be0 = 1'b1; be1 = 1'b1; wp = 1'b0; ad = 16'h0000;
        model_addr = '0;
        #1 check_now("reset_dout", dout, 16'h0000);
        #20;
        @(posedge clk);
        #2 rst = 1'b0;

        // Fill every word so the model knows the whole array.
        latch(16'h0000);
        for (int i = 0; i < DEPTH; i++) wr(16'($urandom), 1'b0, 1'b0, 1'b0);

        // Latch 0 twice, two wait beats, three reads.
        latch(16'h0000); latch(16'h0000);
        wr(16'h0000, 1'b1, 1'b1, 1'b0); wr(16'h0000, 1'b1, 1'b1, 1'b0);
        rd(); rd(); rd();

        // Burst write then readback.
        latch(16'h0010);
        wr(16'h1234, 1'b0, 1'b0, 1'b0); wr(16'hABCD, 1'b0, 1'b0, 1'b0);
        latch(16'h0010);
        rd(); rd();

        // Byte lanes.
        latch(16'h0005); wr(16'hFFFF, 1'b0, 1'b0, 1'b0);
        latch(16'h0005); wr(16'h1200, 1'b1, 1'b0, 1'b0);
        latch(16'h0005); rd();
        latch(16'h0005); wr(16'h0034, 1'b0, 1'b1, 1'b0);
        latch(16'h0005); rd();

        // Write protect: data untouched, address still advances to 9.
        latch(16'h0007); wr(16'h5555, 1'b0, 1'b0, 1'b0); wr(16'h2468, 1'b0, 1'b0, 1'b0);
        wr(16'h9BDF, 1'b0, 1'b0, 1'b0);
        latch(16'h0007);
        wr(16'hAAAA, 1'b0, 1'b0, 1'b1); wr(16'h1111, 1'b0, 1'b0, 1'b1);
        rd();
        latch(16'h0007); rd(); rd();

        // Wrap at top of memory; upper address bits ignored.
        latch(16'hFFFF);
        wr(16'h0001, 1'b0, 1'b0, 1'b0); wr(16'h0002, 1'b0, 1'b0, 1'b0);
        latch(16'h03FF); rd(); rd();

        // Wait variants must not move the address or output.
        latch(16'h0020);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7777);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0021);
        idle();
        rd(); rd();

        // Reset mid-read: output clears at once, next read starts at word 0.
        latch(16'h0003); rd(); rd();
        async_reset();
        rd(); rd();

        // Randomized bus traffic.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0:       latch(16'($urandom));
                1, 2, 3: rd();
                4, 5, 6: wr(16'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
                7:       drive(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0, 16'($urandom));
                8:       idle();
                default: drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                               1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            endcase
            if (n == 300) async_reset();
        end

        idle(); idle();
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
